qsys_serial_slave: RTL

Downstream endpoint of the Qsys serial link: receives the 65-bit command frame driven by the Qsys serial master on `sdi`/`sle`, executes it as a single Avalon-MM access on a local register bus, then returns 32 bits of response on `sdo` framed by `srdy`. Sits on the remote board or FPGA region and shares the link clock with the master; there is no clock recovery.

---
 rtl/qsys_serial_slave_pkg.sv | 20 ++
 rtl/qsys_serial_slave_if.sv | 25 ++
 rtl/qsys_serial_slave_frame_rx.sv | 44 ++++
 rtl/qsys_serial_slave.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/qsys_serial_slave_pkg.sv
// rtl/qsys_serial_slave_pkg.sv - frame constants and FSM states for the Qsys serial slave
// ST_TIMEOUT_ERR exists only when QSYS_SERIAL_SLAVE_TIMEOUT_EN is defined.
package qsys_serial_pkg;
  localparam int FRAME_BITS = 65;
  localparam int RESP_BITS = 32;
  localparam int RW_BIT = 64;
  localparam int CNT_W = 7;
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_BUS_CMD,
    ST_BUS_RDATA,
    ST_RESP
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
    , ST_TIMEOUT_ERR
`endif
  } state_e;
endpackage

// File: rtl/qsys_serial_slave_if.sv
// rtl/qsys_serial_slave_if.sv - local Avalon-MM register bus between the slave and its registers
interface qsys_serial_slave_if #(
  parameter int address_size = 8
);
  logic [address_size-1:0] avm_local_address;
  logic [31:0]             avm_local_writedata;
  logic [3:0]              avm_local_byteenable;
  logic                    avm_local_write;
  logic                    avm_local_read;
  logic [31:0]             avm_local_readdata;
  logic                    avm_local_readdatavalid;
  logic                    avm_local_waitrequest;

  modport master (
    output avm_local_address, avm_local_writedata, avm_local_byteenable,
    output avm_local_write, avm_local_read,
    input  avm_local_readdata, avm_local_readdatavalid, avm_local_waitrequest
  );

  modport slave (
    input  avm_local_address, avm_local_writedata, avm_local_byteenable,
    input  avm_local_write, avm_local_read,
    output avm_local_readdata, avm_local_readdatavalid, avm_local_waitrequest
  );
endinterface

// File: rtl/qsys_serial_slave_frame_rx.sv
// rtl/qsys_serial_slave_frame_rx.sv - serial_frame_rx: 65-bit command deserializer with length check
// Valid/error are flagged in the cycle sle falls so the top can register its response there.
module serial_frame_rx
  import qsys_serial_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_en_i,
  input  logic                  sdi_i,
  input  logic                  sle_i,
  output logic [FRAME_BITS-1:0] frame_o,
  output logic                  frame_valid_o,
  output logic                  frame_err_o
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [FRAME_BITS-1:0] sr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  active_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (active_q) begin
      if (sle_i) begin
        sr_q <= {sr_q[FRAME_BITS-2:0], sdi_i};
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end else begin
        active_q <= 1'b0;
      end
    end else if (start_en_i && sle_i) begin
      sr_q     <= {{(FRAME_BITS-1){1'b0}}, sdi_i};
      cnt_q    <= 7'd1;
      active_q <= 1'b1;
    end
  end

  assign frame_o       = sr_q;
  assign frame_valid_o = active_q & ~sle_i & (cnt_q == CNT_FULL);
  assign frame_err_o   = active_q & ~sle_i & (cnt_q != CNT_FULL);
endmodule

// File: rtl/qsys_serial_slave.sv
// rtl/qsys_serial_slave.sv - Qsys serial link endpoint: frame -> one Avalon-MM access -> 32-bit reply
// Optional bus watchdog: QSYS_SERIAL_SLAVE_TIMEOUT_EN.
module qsys_serial_slave
  import qsys_serial_pkg::*;
#(
  parameter int address_size   = 8,
  parameter int timeout_cycles = 256
) (
  input  logic csi_MCLK_clk,
  input  logic rsi_MRST_reset,
  input  logic sdi,
  input  logic sle,
  output logic sdo,
  output logic srdy,
  output logic frame_err,
  output logic busy,
  qsys_serial_slave_if.master avm
);
  localparam logic [4:0] LAST_BIT = 5'(RESP_BITS - 1);

  if (timeout_cycles < 2 || address_size < 1 || address_size > 31) begin : g_bad_cfg
    $error("qsys_serial_slave: unsupported timeout_cycles/address_size");
  end

  state_e                  state_q;
  logic [address_size-1:0] addr_q;
  logic [31:0]             wdata_q;
  logic                    write_q, read_q;
  logic [31:0]             resp_q;
  logic [4:0]              bitcnt_q;
  logic                    sdo_q, srdy_q, frame_err_q, busy_q;

  logic [FRAME_BITS-1:0]   rx_frame;
  logic                    rx_valid, rx_err;
  logic [31:0]             acc_word;
  logic                    unused_frame_bits;

`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
  localparam int TO_W = $clog2(timeout_cycles + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles - 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  serial_frame_rx u_rx (
    .clk_i         (csi_MCLK_clk),
    .rst_i         (rsi_MRST_reset),
    .start_en_i    (state_q == ST_IDLE),
    .sdi_i         (sdi),
    .sle_i         (sle),
    .frame_o       (rx_frame),
    .frame_valid_o (rx_valid),
    .frame_err_o   (rx_err)
  );

  // Writes always answer zero; reads answer whatever the bus returns.
  assign acc_word = write_q ? 32'h0 : avm.avm_local_readdata;
  assign unused_frame_bits = ^rx_frame[63:32+address_size];

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      resp_q      <= '0;
      bitcnt_q    <= '0;
      sdo_q       <= 1'b0;
      srdy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (sle) begin
          state_q <= ST_SHIFT_IN;
          busy_q  <= 1'b1;
        end
        ST_SHIFT_IN: begin
          if (rx_valid) begin
            state_q <= ST_BUS_CMD;
            addr_q  <= rx_frame[32 +: address_size];
            wdata_q <= rx_frame[31:0];
            write_q <= rx_frame[RW_BIT];
            read_q  <= ~rx_frame[RW_BIT];
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else if (rx_err) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end
        end
        ST_BUS_CMD: begin
          if (!avm.avm_local_waitrequest) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            if (write_q || avm.avm_local_readdatavalid) begin
              state_q  <= ST_RESP;
              srdy_q   <= 1'b1;
              sdo_q    <= acc_word[31];
              resp_q   <= {acc_word[30:0], 1'b0};
              bitcnt_q <= LAST_BIT;
            end else begin
              state_q <= ST_BUS_RDATA;
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            frame_err_q <= 1'b1;
            state_q     <= ST_TIMEOUT_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        ST_BUS_RDATA: begin
          if (avm.avm_local_readdatavalid) begin
            state_q  <= ST_RESP;
            srdy_q   <= 1'b1;
            sdo_q    <= acc_word[31];
            resp_q   <= {acc_word[30:0], 1'b0};
            bitcnt_q <= LAST_BIT;
          end
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_TIMEOUT_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
        ST_TIMEOUT_ERR: begin
          state_q  <= ST_RESP;
          srdy_q   <= 1'b1;
          sdo_q    <= TIMEOUT_WORD[31];
          resp_q   <= {TIMEOUT_WORD[30:0], 1'b0};
          bitcnt_q <= LAST_BIT;
        end
`endif
        ST_RESP: begin
          if (bitcnt_q == 5'd0) begin
            state_q <= ST_IDLE;
            srdy_q  <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            sdo_q    <= resp_q[31];
            resp_q   <= {resp_q[30:0], 1'b0};
            bitcnt_q <= bitcnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avm.avm_local_address    = addr_q;
  assign avm.avm_local_writedata  = wdata_q;
  assign avm.avm_local_byteenable = 4'hF;
  assign avm.avm_local_write      = write_q;
  assign avm.avm_local_read       = read_q;
  assign sdo       = sdo_q;
  assign srdy      = srdy_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
endmodule
